// File: rtl/mc_batch_ctrl.sv
// Monte Carlo batch controller: launches n_runs simulations on one manager,
// counts hits and watchdog timeouts, then divides out an 8-bit hit probability.
module mc_batch_ctrl #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_req,
  input  logic [15:0] n_runs,
  output logic        sim_start,
  input  logic        sim_done,
  input  logic        sim_y,
  output logic        busy,
  output logic        batch_done,
  output logic [15:0] hits,
  output logic [15:0] runs_done,
  output logic [15:0] timeouts,
  output logic [7:0]  prob
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_GUARD, S_WAIT, S_DIV, S_DONE
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] n_lat;
  logic [15:0] timer;

  // Divider: rem < divisor always, dvd holds the dividend bits still to shift in.
  logic [15:0] rem;
  logic [15:0] divisor;
  logic [8:0]  dvd;
  logic [8:0]  quo;
  logic [3:0]  div_cnt;

  logic        timer_hit;
  logic [15:0] hits_nxt;
  logic [15:0] runs_nxt;
  logic [15:0] to_nxt;
  logic [16:0] trial;
  logic        q_bit;
  logic [16:0] rem_nxt;
  logic [8:0]  quo_nxt;

  // NOTE: every always_comb output gets a value on every path (defaults first), so no latches.
  always_comb begin
    timer_hit = (timer == TIMER_LAST);
    hits_nxt  = hits + {15'd0, sim_done & sim_y};
    runs_nxt  = runs_done + 16'd1;
    to_nxt    = timeouts + {15'd0, ~sim_done};
    trial     = {rem, dvd[8]};
    q_bit     = (trial >= {1'b0, divisor});
    rem_nxt   = q_bit ? (trial - {1'b0, divisor}) : trial;
    quo_nxt   = {quo[7:0], q_bit};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      n_lat      <= '0;
      timer      <= '0;
      sim_start  <= 1'b0;
      busy       <= 1'b0;
      batch_done <= 1'b0;
      hits       <= '0;
      runs_done  <= '0;
      timeouts   <= '0;
      prob       <= '0;
      rem        <= '0;
      divisor    <= '0;
      dvd        <= '0;
      quo        <= '0;
      div_cnt    <= '0;
    end else begin
      sim_start <= 1'b0;
      if ((state == S_IDLE || state == S_DONE) && run_req) begin
        n_lat      <= n_runs;
        hits       <= '0;
        runs_done  <= '0;
        timeouts   <= '0;
        prob       <= '0;
        batch_done <= 1'b0;
        busy       <= 1'b1;
        if (n_runs == 16'd0) begin
          state <= S_DONE;
        end else begin
          state     <= S_LAUNCH;
          sim_start <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: ;
          S_LAUNCH: begin
            timer <= '0;
            state <= S_GUARD;
          end
          // The manager clears done on the start edge; a stale high may still show here.
          S_GUARD: state <= S_WAIT;
          S_WAIT: begin
            timer <= timer + 16'd1;
            if (sim_done || timer_hit) begin
              hits      <= hits_nxt;
              runs_done <= runs_nxt;
              timeouts  <= to_nxt;
              if (runs_nxt == n_lat) begin
                state   <= S_DIV;
                divisor <= runs_nxt - to_nxt;
                rem     <= hits_nxt >> 1;
                dvd     <= {hits_nxt[0], 8'd0};
                quo     <= '0;
                div_cnt <= '0;
              end else begin
                state     <= S_LAUNCH;
                sim_start <= 1'b1;
              end
            end
          end
          S_DIV: begin
            if (divisor == 16'd0) begin
              prob       <= '0;
              state      <= S_DONE;
              busy       <= 1'b0;
              batch_done <= 1'b1;
            end else begin
              rem     <= rem_nxt[15:0];
              dvd     <= {dvd[7:0], 1'b0};
              quo     <= quo_nxt;
              div_cnt <= div_cnt + 4'd1;
              if (div_cnt == 4'd8) begin
                prob       <= quo_nxt[8] ? 8'hFF : quo_nxt[7:0];
                state      <= S_DONE;
                busy       <= 1'b0;
                batch_done <= 1'b1;
              end
            end
          end
          S_DONE: begin
            busy       <= 1'b0;
            batch_done <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mc_batch_ctrl.sv
// Bench for mc_batch_ctrl: behavioural simulation-manager model plus a
// per-batch reference model computed from run latencies and outcomes.
module tb_mc_batch_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_req;
  logic [15:0] n_runs;
  logic        sim_start;
  logic        sim_done = 1'b0;
  logic        sim_y = 1'b0;
  logic        busy;
  logic        batch_done;
  logic [15:0] hits;
  logic [15:0] runs_done;
  logic [15:0] timeouts;
  logic [7:0]  prob;

  mc_batch_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .n_runs(n_runs),
    .sim_start(sim_start), .sim_done(sim_done), .sim_y(sim_y),
    .busy(busy), .batch_done(batch_done), .hits(hits),
    .runs_done(runs_done), .timeouts(timeouts), .prob(prob)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Per-run manager behaviour: latency (0 = never completes) and outcome.
  int lat_tab[64];
  int y_tab[64];
  bit stale_mode = 1'b0;
  int run_idx = 0;

  int start_q[$];
  always @(negedge clk) if (sim_start === 1'b1) start_q.push_back(cyc);

  // Manager model: a start clears done (one cycle late in stale mode), then
  // done/y rise lat edges after the start edge.
  int m_cnt = 0;
  int m_y = 0;
  bit m_stale_clr = 1'b0;
  bit start_seen;
  always begin
    @(negedge clk);
    start_seen = (sim_start === 1'b1);
    @(posedge clk);
    #1;
    if (start_seen) begin
      m_cnt = lat_tab[run_idx % 64];
      m_y   = y_tab[run_idx % 64];
      run_idx = run_idx + 1;
      if (stale_mode) m_stale_clr = 1'b1;
      else sim_done = 1'b0;
    end else begin
      if (m_stale_clr) begin
        sim_done = 1'b0;
        m_stale_clr = 1'b0;
      end
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          sim_done = 1'b1;
          sim_y = m_y[0];
        end
      end
    end
  end

  typedef struct {
    int hits, runs, tos, prob;
    int n_starts, first_start, last_start, done_cyc, c0;
    int busy1, extra, bd_after;
  } res_t;

  res_t obs, ex;

  // Reference: each run takes (latency or TIMEOUT) WAIT-side cycles plus LAUNCH and GUARD.
  function automatic res_t model(input int n, input int c0);
    res_t r;
    int l;
    int dv;
    bit ok;
    r = '{default: 0};
    r.first_start = -1;
    r.last_start  = -1;
    l = c0 + 1;
    for (int k = 0; k < n; k++) begin
      ok = (lat_tab[k] != 0) && (lat_tab[k] <= TO);
      if (k == 0) r.first_start = l;
      r.last_start = l;
      r.n_starts++;
      r.runs++;
      if (ok) r.hits += y_tab[k];
      else r.tos++;
      l += (ok ? lat_tab[k] : TO) + 2;
    end
    dv = r.runs - r.tos;
    r.prob = (dv == 0) ? 0 : (((r.hits * 256) / dv > 255) ? 255 : (r.hits * 256) / dv);
    r.done_cyc = (n == 0) ? c0 + 2 : (l - 1) + ((dv == 0) ? 2 : 10);
    r.c0 = c0;
    return r;
  endfunction

  task automatic do_batch(input int n, input int spur_k, output res_t o);
    int k;
    o = '{default: 0};
    start_q.delete();
    run_idx = 0;
    @(negedge clk);
    run_req = 1'b1;
    n_runs  = 16'(n);
    o.c0 = cyc;
    @(negedge clk);
    run_req = 1'b0;
    n_runs  = 16'($urandom);
    o.busy1 = int'(busy);
    k = 0;
    while (batch_done !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
      if (k == spur_k) begin
        run_req = 1'b1;
        n_runs  = 16'd7;
      end else if (k == spur_k + 1) begin
        run_req = 1'b0;
      end
    end
    run_req = 1'b0;
    o.done_cyc = (batch_done === 1'b1) ? cyc : -1;
    o.busy1 = o.busy1 * 2 + int'(busy);
    o.hits = int'(hits);
    o.runs = int'(runs_done);
    o.tos  = int'(timeouts);
    o.prob = int'(prob);
    #1;
    o.n_starts    = start_q.size();
    o.first_start = (start_q.size() > 0) ? start_q[0] : -1;
    o.last_start  = (start_q.size() > 0) ? start_q[start_q.size() - 1] : -1;
    repeat (4) @(negedge clk);
    #1;
    o.extra    = start_q.size() - o.n_starts;
    o.bd_after = int'(batch_done === 1'b1 && busy === 1'b0 && int'(hits) == o.hits);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    run_req = 1'b0;
    n_runs = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({sim_start, busy, batch_done, hits, runs_done, timeouts, prob} !== 52'd0)
      $display("FAIL reset_outputs: got start=%b busy=%b bd=%b h=%0d r=%0d t=%0d p=%0d want all 0",
               sim_start, busy, batch_done, hits, runs_done, timeouts, prob);
    else passed++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (sim_start !== 1'b0 || busy !== 1'b0 || start_q.size() != 0)
      $display("FAIL reset_idle: got start=%b busy=%b starts=%0d want 0 0 0", sim_start, busy, start_q.size());
    else passed++;
  endtask

  task automatic test_basic;
    stale_mode = 1'b0;
    for (int i = 0; i < 4; i++) lat_tab[i] = 5;
    y_tab[0] = 1; y_tab[1] = 0; y_tab[2] = 1; y_tab[3] = 1;
    do_batch(4, 0, obs);
    ex = model(4, obs.c0);
    total++;
    if (obs.hits !== 3 || obs.runs !== 4 || obs.tos !== 0)
      $display("FAIL basic_counts: got h=%0d r=%0d t=%0d want 3 4 0", obs.hits, obs.runs, obs.tos);
    else passed++;
    total++;
    if (obs.prob !== 192) $display("FAIL basic_prob: got %0d want 192", obs.prob);
    else passed++;
    total++;
    if (obs.n_starts !== 4 || obs.first_start !== ex.first_start || obs.last_start !== ex.last_start)
      $display("FAIL basic_starts: got n=%0d first=%0d last=%0d want n=4 first=%0d last=%0d",
               obs.n_starts, obs.first_start, obs.last_start, ex.first_start, ex.last_start);
    else passed++;
    total++;
    if (obs.done_cyc !== ex.done_cyc)
      $display("FAIL basic_done_cycle: got %0d want %0d", obs.done_cyc, ex.done_cyc);
    else passed++;
    total++;
    if (obs.busy1 !== 2) $display("FAIL basic_busy: got code %0d want 2 (busy at launch, low at done)", obs.busy1);
    else passed++;
    total++;
    if (obs.extra !== 0 || obs.bd_after !== 1)
      $display("FAIL basic_hold: got extra=%0d held=%0d want 0 1", obs.extra, obs.bd_after);
    else passed++;
  endtask

  task automatic test_saturate;
    stale_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lat_tab[i] = $urandom_range(1, 8);
      y_tab[i] = 1;
    end
    do_batch(3, 0, obs);
    ex = model(3, obs.c0);
    total++;
    if (obs.hits !== 3 || obs.prob !== 255)
      $display("FAIL sat_prob: got h=%0d p=%0d want 3 255", obs.hits, obs.prob);
    else passed++;
    total++;
    if (obs.done_cyc !== ex.done_cyc || obs.last_start !== ex.last_start)
      $display("FAIL sat_timing: got done=%0d last=%0d want %0d %0d",
               obs.done_cyc, obs.last_start, ex.done_cyc, ex.last_start);
    else passed++;
  endtask

  task automatic test_timeout;
    int gap;
    stale_mode = 1'b0;
    lat_tab[0] = 3; lat_tab[1] = 0; lat_tab[2] = 2;
    for (int i = 0; i < 3; i++) y_tab[i] = 1;
    do_batch(3, 0, obs);
    ex = model(3, obs.c0);
    total++;
    if (obs.hits !== 2 || obs.runs !== 3 || obs.tos !== 1 || obs.prob !== 255)
      $display("FAIL to_counts: got h=%0d r=%0d t=%0d p=%0d want 2 3 1 255",
               obs.hits, obs.runs, obs.tos, obs.prob);
    else passed++;
    gap = (start_q.size() >= 3) ? start_q[2] - (start_q[1] + 2) : -1;
    total++;
    if (gap !== 16) $display("FAIL to_gap: got %0d WAIT cycles before run 3 start want 16", gap);
    else passed++;
    total++;
    if (obs.done_cyc !== ex.done_cyc) $display("FAIL to_done_cycle: got %0d want %0d", obs.done_cyc, ex.done_cyc);
    else passed++;
  endtask

  task automatic test_back_to_back;
    stale_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lat_tab[i] = 1;
      y_tab[i] = int'($urandom_range(0, 1));
    end
    lat_tab[3] = TO;
    y_tab[3] = 0;
    y_tab[0] = 1;
    do_batch(6, 2, obs);
    ex = model(6, obs.c0);
    total++;
    if (obs.hits !== ex.hits || obs.runs !== 6 || obs.tos !== 0)
      $display("FAIL b2b_counts: got h=%0d r=%0d t=%0d want %0d 6 0", obs.hits, obs.runs, obs.tos, ex.hits);
    else passed++;
    total++;
    if (obs.prob !== ex.prob) $display("FAIL b2b_prob: got %0d want %0d", obs.prob, ex.prob);
    else passed++;
    total++;
    if (obs.n_starts !== 6 || obs.last_start !== ex.last_start || obs.done_cyc !== ex.done_cyc)
      $display("FAIL b2b_timing: got n=%0d last=%0d done=%0d want 6 %0d %0d",
               obs.n_starts, obs.last_start, obs.done_cyc, ex.last_start, ex.done_cyc);
    else passed++;
    total++;
    if (obs.extra !== 0 || obs.bd_after !== 1)
      $display("FAIL b2b_no_extra_batch: got extra=%0d held=%0d want 0 1", obs.extra, obs.bd_after);
    else passed++;
    stale_mode = 1'b0;
  endtask

  task automatic test_zero_runs;
    do_batch(0, 0, obs);
    ex = model(0, obs.c0);
    total++;
    if (obs.done_cyc !== ex.done_cyc) $display("FAIL zero_done_cycle: got %0d want %0d", obs.done_cyc, ex.done_cyc);
    else passed++;
    total++;
    if (obs.n_starts !== 0 || obs.hits !== 0 || obs.runs !== 0 || obs.tos !== 0 || obs.prob !== 0)
      $display("FAIL zero_counts: got n=%0d h=%0d r=%0d t=%0d p=%0d want all 0",
               obs.n_starts, obs.hits, obs.runs, obs.tos, obs.prob);
    else passed++;
    total++;
    if (obs.busy1 !== 2 || obs.bd_after !== 1)
      $display("FAIL zero_busy: got code=%0d held=%0d want 2 1", obs.busy1, obs.bd_after);
    else passed++;
  endtask

  task automatic test_all_timeout;
    lat_tab[0] = 0; lat_tab[1] = TO + 1;
    y_tab[0] = 1; y_tab[1] = 1;
    do_batch(2, 0, obs);
    ex = model(2, obs.c0);
    total++;
    if (obs.tos !== 2 || obs.runs !== 2 || obs.hits !== 0 || obs.prob !== 0)
      $display("FAIL allto_counts: got h=%0d r=%0d t=%0d p=%0d want 0 2 2 0",
               obs.hits, obs.runs, obs.tos, obs.prob);
    else passed++;
    total++;
    if (obs.done_cyc !== ex.done_cyc) $display("FAIL allto_done_cycle: got %0d want %0d", obs.done_cyc, ex.done_cyc);
    else passed++;
  endtask

  task automatic test_random;
    int n;
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, 9);
      stale_mode = bit'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        lat_tab[i] = $urandom_range(0, 18);
        y_tab[i] = int'($urandom_range(0, 1));
      end
      do_batch(n, 0, obs);
      ex = model(n, obs.c0);
      total++;
      if (obs.hits !== ex.hits || obs.runs !== ex.runs || obs.tos !== ex.tos || obs.prob !== ex.prob)
        $display("FAIL rand%0d_result: got h=%0d r=%0d t=%0d p=%0d want %0d %0d %0d %0d", b,
                 obs.hits, obs.runs, obs.tos, obs.prob, ex.hits, ex.runs, ex.tos, ex.prob);
      else passed++;
      total++;
      if (obs.n_starts !== ex.n_starts || obs.last_start !== ex.last_start || obs.done_cyc !== ex.done_cyc)
        $display("FAIL rand%0d_timing: got n=%0d last=%0d done=%0d want %0d %0d %0d", b,
                 obs.n_starts, obs.last_start, obs.done_cyc, ex.n_starts, ex.last_start, ex.done_cyc);
      else passed++;
    end
    stale_mode = 1'b0;
  endtask

  task automatic test_async_reset;
    int n0;
    stale_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lat_tab[i] = 2;
      y_tab[i] = 1;
    end
    start_q.delete();
    run_idx = 0;
    @(negedge clk);
    run_req = 1'b1;
    n_runs = 16'd4;
    @(negedge clk);
    run_req = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (hits !== 16'd2 || busy !== 1'b1)
      $display("FAIL arst_pre: got h=%0d busy=%b want 2 1", hits, busy);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({sim_start, busy, batch_done, hits, runs_done, timeouts, prob} !== 52'd0)
      $display("FAIL arst_outputs: got start=%b busy=%b bd=%b h=%0d r=%0d t=%0d p=%0d want all 0",
               sim_start, busy, batch_done, hits, runs_done, timeouts, prob);
    else passed++;
    n0 = start_q.size();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    total++;
    if (start_q.size() !== n0 || busy !== 1'b0 || batch_done !== 1'b0)
      $display("FAIL arst_quiet: got starts=%0d busy=%b bd=%b want %0d 0 0", start_q.size(), busy, batch_done, n0);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      lat_tab[i] = $urandom_range(1, 12);
      y_tab[i] = int'($urandom_range(0, 1));
    end
    do_batch(5, 0, obs);
    ex = model(5, obs.c0);
    total++;
    if (obs.hits !== ex.hits || obs.runs !== 5 || obs.prob !== ex.prob || obs.done_cyc !== ex.done_cyc)
      $display("FAIL arst_rerun: got h=%0d r=%0d p=%0d done=%0d want %0d 5 %0d %0d",
               obs.hits, obs.runs, obs.prob, obs.done_cyc, ex.hits, ex.prob, ex.done_cyc);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_saturate;
    test_timeout;
    test_back_to_back;
    test_zero_runs;
    test_all_timeout;
    test_random;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
